mealy_seq_detect: RTL
=====================

Name: mealy_seq_detect

Overview:
- Parametrised, runtime-programmable serial pattern detector; successor to the fixed "1101" Mealy detector.
- Pattern, length and overlap mode are loaded through a config port; the match output is Mealy (same cycle as the final bit).
- A saturating counter tallies matches.
- Sits between a serial bit source and the status/interrupt logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] is the last; bits above cfg_len-1 are ignored.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length, legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- cfg_err  out  1  one-cycle pulse: load rejected.
- armed  out  1  high when a valid config is held.
- i_valid  in  1  serial bit qualifier.
- i  in  1  serial data bit.
- clr_count  in  1  synchronous clear of match_count.
- o  out  1  Mealy match, combinational.
- match_count  out  CNT_W  saturating match tally.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=UNCONFIG; history, fill, pattern, len and overlap all cleared.
  - cfg_err=0, match_count=0, armed=0, o=0.
- States:
  - UNCONFIG: o forced to 0; input bits ignored.
  - ARMED: detection active.
- Transitions:
  - Any state + cfg_load with a legal cfg_len → ARMED.
  - Illegal cfg_len (0 or >MAX_LEN) → state and stored config unchanged, cfg_err=1 for the next cycle.
- Config latch:
  - Captures pattern, len and overlap.
  - Clears history and fill.
  - Leaves match_count untouched.
- History:
  - hist is a shift register of MAX_LEN-1 bits; newest bit at [0].
  - fill counts valid history bits and saturates at MAX_LEN-1.
- Match:
  - o = ARMED & i_valid & !cfg_load & (fill ≥ len-1) & ({hist[len-2:0], i} == pattern[len-1:0]).
  - For len=1, o = ARMED & i_valid & !cfg_load & (i == pattern[0]).
  - No registered delay: o is valid in the same cycle as the final bit.
- Clock-edge update, when ARMED & i_valid & !cfg_load:
  - If o=1 and overlap=0: fill←0; hist is don't-care.
  - Otherwise: hist←{hist[MAX_LEN-3:0], i}, fill←min(fill+1, MAX_LEN-1).
- i_valid=0: hist and fill hold; o=0.
- match_count:
  - Increments on every clock edge where o=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - cfg_load with i_valid: load wins; the bit is discarded and o=0.
  - clr_count with a match: clear wins; count becomes 0.
  - rst overrides everything.
- Mid-stream reload: partial prefixes in flight are lost; a match is only possible after len new valid bits.
- Latency: config takes effect for the bit presented on the cycle after cfg_load; match_count reflects a match one cycle after o.

Decomposition:
- Package mealy_pkg:
  - state enum {UNCONFIG, ARMED}.
  - Function for the LEN_W width calc.
  - Pattern-mask helper function (ones in the low len bits).
- Sub-module sat_counter (parameter W; ports inc, clr, count) holds the saturating tally.
- History, fill and the FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with i_valid=1, i=1 → o=0, armed=0, match_count=0, cfg_err=0.
- Overlap: load 1101 (cfg_pattern=8'b0000_1101, len=4, overlap=1), stream 1101101 → o=1 on bits 4 and 7 only; match_count=2.
- Non-overlap: same load with overlap=0, stream 1101101 → o=1 on bit 4 only; match_count=1.
- Illegal config: cfg_len=0 then cfg_len=9 while ARMED with 1101 → cfg_err pulses each time; 1101 still detected afterwards.
- Length extremes:
  - len=1, pattern=1, stream 0110 → o on bits 2 and 3.
  - len=8, pattern=8'hA5 with idle gaps (i_valid=0) between bits → single match.
- Collisions and saturation:
  - Cycle with cfg_load + final matching bit → o=0.
  - Cycle with clr_count + match → count=0.
  - CNT_W=2, drive 5 matches → count holds at 3.

Source files
------------

// File: rtl/mealy_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package mealy_pkg;

    typedef enum logic {
        UNCONFIG = 1'b0,
        ARMED    = 1'b1
    } state_t;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Ones in the low len bits; callers truncate to their pattern width (len <= 32).
    function automatic logic [31:0] len_mask(input int len);
        logic [32:0] one_hot;
        one_hot = 33'd1 << len;
        return one_hot[31:0] - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment wins.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mealy_seq_detect.sv
// Runtime-programmable serial pattern detector with a same-cycle (Mealy) match
// output and a saturating match tally.
module mealy_seq_detect
    import mealy_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    output logic               armed,
    input  logic               i_valid,
    input  logic               i,
    input  logic               clr_count,
    output logic               o,
    output logic [CNT_W-1:0]   match_count
);

    localparam int               H_W      = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    state_t             state;
    logic [H_W-1:0]     hist;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] pattern;
    logic               overlap;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] window;
    logic [LEN_W:0]     fill_p1;
    logic               cfg_ok;
    logic               fill_ok;
    logic               pat_ok;
    logic               take_bit;

    // The current bit joins the history as the newest (last-received) position.
    assign window   = {hist, i};
    assign mask     = MAX_LEN'(len_mask(int'(len)));
    assign fill_p1  = {1'b0, fill} + 1'b1;
    assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign fill_ok  = fill_p1 >= {1'b0, len};
    assign pat_ok   = ((window ^ pattern) & mask) == '0;
    assign take_bit = (state == ARMED) && i_valid && !cfg_load;
    assign o        = take_bit && fill_ok && pat_ok;
    assign armed    = (state == ARMED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= UNCONFIG;
            hist    <= '0;
            fill    <= '0;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load) begin
                // A rejected load leaves the state and the whole stored setup alone.
                if (cfg_ok) begin
                    state   <= ARMED;
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    overlap <= cfg_overlap;
                    hist    <= '0;
                    fill    <= '0;
                end
            end else begin
                case (state)
                    UNCONFIG: ;
                    ARMED: begin
                        if (take_bit) begin
                            if (o && !overlap) begin
                                fill <= '0;
                            end else begin
                                hist <= window[H_W-1:0];
                                fill <= (fill == FILL_MAX) ? fill : fill + 1'b1;
                            end
                        end
                    end
                    default: state <= UNCONFIG;
                endcase
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_count (
        .clk  (clk),
        .rst  (rst),
        .inc  (o),
        .clr  (clr_count),
        .count(match_count)
    );

endmodule
